// File: rtl/axil_regfile_slave.sv
// axil_regfile_slave: AXI4-Lite register file with byte strobes, decode errors and a parallel register image.
module axil_regfile_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           wvalid,
  output logic                           wready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [1:0]                     bresp,
  input  logic                           arvalid,
  output logic                           arready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int SB = $clog2(NB);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * NB);
  logic init, aw_full, w_full;
  logic [ADDR_WIDTH-1:0] aw_q, wa, w_off, r_off;
  logic [DATA_WIDTH-1:0] w_q, wd;
  logic [NB-1:0] s_q, ws;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic aw_hs, w_hs, ar_hs, commit, w_ok, r_ok;
  logic [IW-1:0] w_idx, r_idx;
  assign awready = init & ~aw_full & ~bvalid;
  assign wready = init & ~w_full & ~bvalid;
  assign arready = init & ~rvalid;
  assign aw_hs = awvalid & awready;
  assign w_hs = wvalid & wready;
  assign ar_hs = arvalid & arready;
  // A slot arriving this cycle is used directly so same-cycle AW/W commits without an extra bubble.
  assign wa = aw_full ? aw_q : awaddr;
  assign wd = w_full ? w_q : wdata;
  assign ws = w_full ? s_q : wstrb;
  assign commit = (aw_full | aw_hs) & (w_full | w_hs);
  assign w_off = wa - BASE_ADDR;
  assign r_off = araddr - BASE_ADDR;
  assign w_ok = (w_off[SB-1:0] == '0) && (w_off < SPAN);
  assign r_ok = (r_off[SB-1:0] == '0) && (r_off < SPAN);
  assign w_idx = w_off[SB+IW-1:SB];
  assign r_idx = r_off[SB+IW-1:SB];
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_img
    assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init <= 1'b0;
      aw_full <= 1'b0;
      w_full <= 1'b0;
      aw_q <= '0;
      w_q <= '0;
      s_q <= '0;
      bvalid <= 1'b0;
      bresp <= 2'b00;
      rvalid <= 1'b0;
      rresp <= 2'b00;
      rdata <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      init <= 1'b1;
      if (bvalid & bready) bvalid <= 1'b0;
      if (commit) begin
        aw_full <= 1'b0;
        w_full <= 1'b0;
        bvalid <= 1'b1;
        bresp <= w_ok ? 2'b00 : 2'b10;
        if (w_ok)
          for (int b = 0; b < NB; b++)
            if (ws[b]) regs[w_idx][b*8 +: 8] <= wd[b*8 +: 8];
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
          aw_q <= awaddr;
        end
        if (w_hs) begin
          w_full <= 1'b1;
          w_q <= wdata;
          s_q <= wstrb;
        end
      end
      if (ar_hs) begin
        rvalid <= 1'b1;
        rdata <= r_ok ? regs[r_idx] : '0;
        rresp <= r_ok ? 2'b00 : 2'b10;
      end else if (rvalid & rready) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_regfile_slave.sv
// tb_axil_regfile_slave: directed AXI4-Lite stimulus with a queue-based response scoreboard.
module tb_axil_regfile_slave;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;
  logic awready, wready, arready, bvalid, rvalid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [511:0] regs_o;
  logic [31:0] exp_regs [16];
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  int checks = 0;
  int errors = 0;

  axil_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .regs_o(regs_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every B/R handshake is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) chk("unexpected bvalid", 1, 0);
      else chk("bresp", bresp, bq.pop_front());
    end
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) chk("unexpected rvalid", 1, 0);
      else chk("rdata/rresp", {rdata, rresp}, rq.pop_front());
    end
  end

  task automatic aw_send(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    awvalid = 1'b1;
    awaddr = a;
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("awready timeout", 0, 1);
    @(posedge clk);
    #1 awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    wvalid = 1'b1;
    wdata = d;
    wstrb = s;
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("wready timeout", 0, 1);
    @(posedge clk);
    #1 wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] a);
    int n = 0;
    @(negedge clk);
    arvalid = 1'b1;
    araddr = a;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("arready timeout", 0, 1);
    @(posedge clk);
    #1 arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] r, input int aw_dly, input int w_dly);
    bq.push_back(r);
    fork
      begin repeat (aw_dly) @(negedge clk); aw_send(a); end
      begin repeat (w_dly) @(negedge clk); w_send(d, s); end
    join
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    rq.push_back({d, r});
    ar_send(a);
  endtask

  task automatic check_img(input string tag);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s word %0d", tag, i), regs_o[i*32 +: 32], exp_regs[i]);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " bvalid"}, bvalid, 0);
    chk({tag, " rvalid"}, rvalid, 0);
    chk({tag, " readys"}, {awready, wready, arready}, 0);
    chk({tag, " rdata"}, rdata, 0);
    chk({tag, " resps"}, {bresp, rresp}, 0);
    chk({tag, " regs_o"}, (regs_o == '0), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst_n = 1'b1;
    #1 chk("ready before init", {awready, wready, arready}, 0);
    @(negedge clk);
    chk("ready after init", {awready, wready, arready}, 3'b111);

    do_write(BASE + 32'h8, 32'hDEAD_BEEF, 4'hF, 2'b00, 0, 0);
    chk("same-cycle bvalid latency", bvalid, 1);
    exp_regs[2] = 32'hDEAD_BEEF;
    check_img("full write");
    do_read(BASE + 32'h8, 32'hDEAD_BEEF, 2'b00);

    do_write(BASE + 32'h8, 32'h1122_3344, 4'b0101, 2'b00, 0, 0);
    exp_regs[2] = 32'hDE22_BE44;
    check_img("partial strobe");
    do_read(BASE + 32'h8, 32'hDE22_BE44, 2'b00);

    do_write(BASE + 32'h1C, 32'hCAFE_F00D, 4'hF, 2'b00, 3, 0);
    chk("W-first bvalid latency", bvalid, 1);
    exp_regs[7] = 32'hCAFE_F00D;
    check_img("W first");
    do_write(BASE + 32'h28, 32'h0BAD_C0DE, 4'hF, 2'b00, 0, 3);
    chk("AW-first bvalid latency", bvalid, 1);
    exp_regs[10] = 32'h0BAD_C0DE;
    check_img("AW first");

    do_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0);
    do_write(BASE + 32'h2, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0);
    do_write(BASE + 32'h8, 32'h0000_0000, 4'h0, 2'b00, 0, 0);
    do_write(BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 2'b10, 0, 0);
    check_img("errors and zero strobe");
    do_write(BASE + 32'h3C, 32'hFFFF_0001, 4'hF, 2'b00, 0, 0);
    exp_regs[15] = 32'hFFFF_0001;
    check_img("last word");
    do_read(BASE + 32'h40, 32'h0, 2'b10);
    do_read(BASE + 32'h6, 32'h0, 2'b10);
    do_read(BASE + 32'h3C, 32'hFFFF_0001, 2'b00);

    @(posedge clk);
    #1 begin bready = 1'b0; rready = 1'b0; end
    fork
      do_write(BASE + 32'hC, 32'h1234_5678, 4'hF, 2'b00, 0, 0);
      do_read(BASE + 32'h8, 32'hDE22_BE44, 2'b00);
    join
    exp_regs[3] = 32'h1234_5678;
    repeat (5) begin
      @(negedge clk);
      chk("bp bvalid/rvalid", {bvalid, rvalid}, 2'b11);
      chk("bp bresp/rresp", {bresp, rresp}, 0);
      chk("bp rdata", rdata, 32'hDE22_BE44);
      chk("bp readys", {awready, wready, arready}, 0);
    end
    @(posedge clk);
    #1 begin bready = 1'b1; rready = 1'b1; end
    check_img("backpressure");

    fork
      do_write(BASE + 32'h14, 32'h0000_00A5, 4'hF, 2'b00, 0, 0);
      do_read(BASE + 32'h14, 32'h0, 2'b00);
    join
    exp_regs[5] = 32'h0000_00A5;
    do_read(BASE + 32'h14, 32'h0000_00A5, 2'b00);
    check_img("read/commit race");

    for (int n = 0; n < 100 && (bq.size() != 0 || rq.size() != 0); n++) @(negedge clk);
    chk("queues drained", bq.size() + rq.size(), 0);

    aw_send(BASE + 32'h10);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("mid-write reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
    w_send(32'h5555_5555, 4'hF);
    repeat (5) begin
      @(negedge clk);
      chk("no bvalid after reset", bvalid, 0);
    end
    check_img("after reset");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/axil_regfile_slave.md
# axil_regfile_slave

Parametrised AXI4-Lite slave register file, successor to the fixed 8×32 slave. Provides NUM_REGS words of DATA_WIDTH with byte strobes and independent AW/W acceptance. Decodes addresses with SLVERR on out-of-range or misaligned access, and exports all registers in parallel to fabric logic. Sits on the AXI4-Lite interconnect as a leaf control/status target.

## Interface
- DATA_WIDTH, 32, data width; must be 32 or 64
- ADDR_WIDTH, 32, AXI address width
- NUM_REGS, 16, number of words; power of two, 2..256
- BASE_ADDR, 0, byte address of word 0; aligned to NUM_REGS*DATA_WIDTH/8
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- awvalid, awready  in/out  1  write address handshake
- awaddr  in  ADDR_WIDTH  write byte address
- wvalid, wready  in/out  1  write data handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte enables
- bvalid  out  1 / bready  in  1  write response handshake
- bresp  out  2  00 OKAY, 10 SLVERR
- arvalid, arready  in/out  1  read address handshake
- araddr  in  ADDR_WIDTH  read byte address
- rvalid  out  1 / rready  in  1  read data handshake
- rdata  out  DATA_WIDTH  read data
- rresp  out  2  00 OKAY, 10 SLVERR
- regs_o  out  NUM_REGS*DATA_WIDTH  parallel register image, word i at [i*DATA_WIDTH +: DATA_WIDTH]

## Operation
- Decode: offset = addr - BASE_ADDR; SB = log2(DATA_WIDTH/8).
  - Access is valid iff offset[SB-1:0]==0 and offset < NUM_REGS*DATA_WIDTH/8.
  - Index = offset[SB+log2(NUM_REGS)-1:SB].
- Write path, two holding slots (AW, W), each filled independently on its handshake, in either order or in the same cycle.
  - awready = init & ~aw_full & ~bvalid; wready = init & ~w_full & ~bvalid.
  - Commit fires on the cycle both slots are full.
    - Valid address: bytes with wstrb[i]=1 are written; the others are kept. bresp=OKAY.
    - Invalid address: no register changes; bresp=SLVERR.
    - wstrb=0 on a valid address: no change; bresp=OKAY.
  - Commit clears both slots and sets bvalid. bvalid holds with a stable bresp until bready is seen.
  - At most one write outstanding: no new AW/W is accepted while bvalid=1.
- Read path:
  - arready = init & ~rvalid.
  - On AR handshake, rdata/rresp are registered and rvalid=1.
    - Valid address: rdata = register word, rresp=OKAY.
    - Invalid address: rdata = 0, rresp=SLVERR.
  - rdata/rresp/rvalid hold until rready is seen.
- Read and write paths are fully independent and may be active in the same cycle.
- regs_o is a direct register image; it updates on the commit edge.

## Timing
- Reset, asynchronous:
  - All registers, regs_o, rdata = 0.
  - bresp, rresp = 00.
  - bvalid, rvalid, awready, wready, arready = 0.
  - Slots are emptied; init = 0.
- init goes to 1 on the first clock edge after rst_n deasserts, so the ready signals rise one cycle after release.
- Write latency: AW and W both handshaking in cycle T gives commit at the end of T and bvalid=1 in T+1. If W arrives k cycles after AW, commit happens at the end of the W cycle.
- B handshake in cycle T+1 returns awready/wready to 1 in T+2. Peak write throughput is one write per 2 cycles.
- Read latency: AR handshake in T gives rvalid in T+1. R handshake in T+1 gives arready=1 in T+2.
- Same-cycle read and commit to the same word: the read returns the pre-write value. A read whose AR handshake falls on the cycle after the commit returns the new value.
- Reset asserted mid-transaction: all in-flight state is discarded immediately. No response is issued afterwards.
- The ready signals never depend combinationally on the valid signals; they are functions of registered state only.

## Test plan
- Write 0xDEADBEEF to BASE+0x8 with wstrb=F, AW and W in the same cycle -> bvalid next cycle, bresp=00; regs_o word 2 = 0xDEADBEEF; read of 0x8 returns it with rresp=00.
- Partial strobe: word 2 = 0xDEADBEEF, then write 0x11223344 with wstrb=0101 -> word 2 = 0xDE22BE44.
- W 3 cycles before AW, and separately AW 3 cycles before W -> a single commit, correct data, and bvalid exactly one cycle after the later handshake.
- Out-of-range write to BASE+NUM_REGS*4, and misaligned write to BASE+0x2 -> bresp=10 with no register changed. Read of BASE+NUM_REGS*4 -> rdata=0, rresp=10.
- Backpressure: bready and rready held low for 5 cycles -> bvalid/rvalid and their data held stable; awready/wready/arready stay 0 throughout.
- Read and commit to word 5 in the same cycle (old 0x0, new 0xA5) -> rdata=0x0. A follow-up read returns 0xA5. Reset pulse mid-write -> all outputs 0, no bvalid afterwards.
